gsbus_tx: RTL and testbench

Serialises outgoing control-bus transactions (16-bit gpreg, 64-bit address, 32-bit data) into a framed byte stream and writes it into the byte-wide TX FIFO toward the PC. It is the transmit counterpart of the host-side command parser and uses the same field layout. Typical uses are register read-back, status words and acknowledgements from `control`. It sits between the control logic and the FT232H TX FIFO write port.

---
 rtl/gsbus_pkg.sv | 27 ++
 rtl/gsbus_tx.sv | 90 +++++++++
 tb/tb_gsbus_tx.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gsbus_pkg.sv
// rtl/gsbus_pkg.sv - shared gsbus frame constants, transaction type and state encoding
package gsbus_pkg;

    localparam logic [7:0] GSBUS_SYNC      = 8'hA5;
    localparam int         GSBUS_FRAME_LEN = 16;
    localparam int         GSBUS_GPREG_W   = 16;
    localparam int         GSBUS_ADDR_W    = 64;
    localparam int         GSBUS_DATA_W    = 32;
    localparam int         GSBUS_PAYLOAD_W = GSBUS_GPREG_W + GSBUS_ADDR_W + GSBUS_DATA_W;

    typedef struct packed {
        logic [GSBUS_GPREG_W-1:0] gpreg;
        logic [GSBUS_ADDR_W-1:0]  addr;
        logic [GSBUS_DATA_W-1:0]  data;
    } gsbus_txn_t;

    typedef enum logic [0:0] {
        GSBUS_TX_IDLE = 1'b0,
        GSBUS_TX_SEND = 1'b1
    } gsbus_tx_state_e;

    // Payload in wire order: gpreg, addr, data, each MSB first.
    function automatic logic [GSBUS_PAYLOAD_W-1:0] gsbus_pack(input gsbus_txn_t txn);
        return {txn.gpreg, txn.addr, txn.data};
    endfunction

endpackage

// File: rtl/gsbus_tx.sv
// rtl/gsbus_tx.sv - serialises gsbus transactions into 16-byte framed writes to the TX FIFO
module gsbus_tx
    import gsbus_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = GSBUS_SYNC,
    parameter int         CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [GSBUS_GPREG_W-1:0] req_gpreg,
    input  logic [GSBUS_ADDR_W-1:0]  req_addr,
    input  logic [GSBUS_DATA_W-1:0]  req_data,
    input  logic                     fifo_full,
    output logic                     fifo_wrreq,
    output logic [7:0]               fifo_data,
    output logic                     busy,
    output logic [CNT_W-1:0]         frame_count
);

    localparam logic [0:0] ST_IDLE  = GSBUS_TX_IDLE;
    localparam logic [0:0] ST_SEND  = GSBUS_TX_SEND;
    localparam logic [3:0] LAST_IDX = 4'(GSBUS_FRAME_LEN - 1);

    logic [0:0]                 state;
    logic [GSBUS_PAYLOAD_W-1:0] shreg;
    logic [3:0]                 idx;
    logic [7:0]                 csum;
    logic [7:0]                 cur_byte;
    gsbus_txn_t                 req_txn;

    assign req_txn = '{gpreg: req_gpreg, addr: req_addr, data: req_data};

    // Payload bytes always come from the top of the shift register; sync and
    // checksum are substituted at the frame ends.
    always_comb begin
        cur_byte = 8'h00;
        if (state == ST_SEND) begin
            if (idx == 4'd0)
                cur_byte = SYNC_BYTE;
            else if (idx == LAST_IDX)
                cur_byte = csum;
            else
                cur_byte = shreg[GSBUS_PAYLOAD_W-1 -: 8];
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state == ST_SEND);
    assign fifo_wrreq = (state == ST_SEND) && !fifo_full;
    assign fifo_data  = cur_byte;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            idx         <= '0;
            csum        <= '0;
            frame_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        shreg <= gsbus_pack(req_txn);
                        idx   <= '0;
                        csum  <= '0;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!fifo_full) begin
                        if (idx == LAST_IDX) begin
                            state       <= ST_IDLE;
                            frame_count <= frame_count + CNT_W'(1);
                        end else begin
                            idx <= idx + 4'd1;
                            if (idx != 4'd0) begin
                                csum  <= csum + cur_byte;
                                shreg <= {shreg[GSBUS_PAYLOAD_W-9:0], 8'h00};
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gsbus_tx.sv
// tb/tb_gsbus_tx.sv - scoreboard testbench for gsbus_tx
module tb_gsbus_tx;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req_valid, req_ready;
    logic [15:0] req_gpreg;
    logic [63:0] req_addr;
    logic [31:0] req_data;
    logic        fifo_full, fifo_wrreq, busy;
    logic [7:0]  fifo_data;
    logic [15:0] frame_count;

    logic        req_valid2, req_ready2, fifo_full2, fifo_wrreq2, busy2;
    logic [7:0]  fifo_data2;
    logic [1:0]  frame_count2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int accepts = 0;

    logic [7:0] exp_q[$];
    int         wr_cyc_q[$];
    logic [7:0] wr_byte_q[$];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gsbus_tx dut (
        .clk(clk), .nrst(nrst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_gpreg(req_gpreg), .req_addr(req_addr), .req_data(req_data),
        .fifo_full(fifo_full), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
        .busy(busy), .frame_count(frame_count)
    );

    gsbus_tx #(.SYNC_BYTE(8'hA5), .CNT_W(2)) dut2 (
        .clk(clk), .nrst(nrst),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_gpreg(req_gpreg), .req_addr(req_addr), .req_data(req_data),
        .fifo_full(fifo_full2), .fifo_wrreq(fifo_wrreq2), .fifo_data(fifo_data2),
        .busy(busy2), .frame_count(frame_count2)
    );

    // Scoreboard: every written byte is popped against the expected stream.
    always @(negedge clk) begin
        if (nrst === 1'b1 && req_valid === 1'b1 && req_ready === 1'b1)
            accepts++;
        if (nrst === 1'b1 && fifo_wrreq === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            wr_byte_q.push_back(fifo_data);
            checks++;
            if (fifo_full !== 1'b0) begin
                errors++;
                $display("FAIL overflow: fifo_wrreq=1 with fifo_full=%b at cycle %0d", fifo_full, cyc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %02h, no byte expected at cycle %0d", fifo_data, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (fifo_data !== mon_exp) begin
                    errors++;
                    $display("FAIL byte: got %02h, expected %02h at cycle %0d", fifo_data, mon_exp, cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step();
    endtask

    task automatic clear_mon();
        exp_q.delete();
        wr_cyc_q.delete();
        wr_byte_q.delete();
        accepts = 0;
    endtask

    function automatic void push_frame(input logic [15:0] g, input logic [63:0] a, input logic [31:0] d);
        logic [7:0] b[16];
        logic [7:0] s;
        b[0] = 8'hA5;
        b[1] = g[15:8];
        b[2] = g[7:0];
        for (int k = 0; k < 8; k++) b[3+k]  = a[63-8*k -: 8];
        for (int k = 0; k < 4; k++) b[11+k] = d[31-8*k -: 8];
        s = 8'h00;
        for (int k = 1; k < 15; k++) s = s + b[k];
        b[15] = s;
        for (int k = 0; k < 16; k++) exp_q.push_back(b[k]);
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n <= 100) begin
            step();
            n++;
        end
        if (n > 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: req_ready=%b, expected 1 within 100 cycles", req_ready);
        end
    endtask

    // Presents one request in a ready cycle, returns that accept cycle, then scrambles the fields.
    task automatic send(input logic [15:0] g, input logic [63:0] a, input logic [31:0] d, output int n);
        wait_ready();
        req_gpreg = g;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        push_frame(g, a, d);
        n = cyc;
        step();
        req_valid = 1'b0;
        req_gpreg = 16'($urandom);
        req_addr  = {$urandom, $urandom};
        req_data  = $urandom;
    endtask

    task automatic test_reset();
        nrst = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0;
        req_gpreg = '0; req_addr = '0; req_data = '0;
        fifo_full = 1'b0; fifo_full2 = 1'b0;
        #3;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", req_ready); end
        checks++; if (fifo_wrreq !== 1'b0) begin errors++; $display("FAIL reset_wrreq: got %b, expected 0", fifo_wrreq); end
        checks++; if (fifo_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, expected 00", fifo_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", frame_count); end
        step(); step();
        nrst = 1'b1;
        step();
    endtask

    task automatic test_single();
        int n;
        clear_mon();
        send(16'h0001, 64'h10, 32'hFF, n);
        wait_cyc(n + 8);
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL single_busy: busy=%b ready=%b, expected 1/0", busy, req_ready); end
        wait_cyc(n + 17);
        checks++; if (wr_cyc_q.size() != 16) begin errors++; $display("FAIL single_len: got %0d bytes, expected 16", wr_cyc_q.size()); end
        checks++; if ((wr_cyc_q.size() > 0 ? wr_cyc_q[0] : -1) != n + 1) begin errors++; $display("FAIL single_first: got cycle %0d, expected %0d", (wr_cyc_q.size() > 0 ? wr_cyc_q[0] : -1), n + 1); end
        checks++; if ((wr_cyc_q.size() > 0 ? wr_cyc_q[$] : -1) != n + 16) begin errors++; $display("FAIL single_last: got cycle %0d, expected %0d", (wr_cyc_q.size() > 0 ? wr_cyc_q[$] : -1), n + 16); end
        checks++; if ((wr_byte_q.size() == 16 ? wr_byte_q[15] : 8'hxx) !== 8'h10) begin errors++; $display("FAIL single_csum: got %02h, expected 10", (wr_byte_q.size() == 16 ? wr_byte_q[15] : 8'hxx)); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d, expected 1", frame_count); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b, expected 1 at N+17", req_ready); end
    endtask

    task automatic test_backpressure();
        int n;
        logic [15:0] fc0;
        clear_mon();
        fc0 = frame_count;
        send(16'h0001, 64'h10, 32'hFF, n);
        fifo_full = 1'b1;
        wait_cyc(n + 4);
        fifo_full = 1'b0;
        wait_cyc(n + 19);
        fifo_full = 1'b1;
        wait_cyc(n + 21);
        fifo_full = 1'b0;
        wait_cyc(n + 22);
        checks++; if (wr_cyc_q.size() != 16) begin errors++; $display("FAIL bp_len: got %0d bytes, expected 16", wr_cyc_q.size()); end
        checks++; if ((wr_cyc_q.size() > 0 ? wr_cyc_q[0] : -1) != n + 4) begin errors++; $display("FAIL bp_first: got cycle %0d, expected %0d", (wr_cyc_q.size() > 0 ? wr_cyc_q[0] : -1), n + 4); end
        checks++; if ((wr_cyc_q.size() > 0 ? wr_cyc_q[$] : -1) != n + 21) begin errors++; $display("FAIL bp_last: got cycle %0d, expected %0d", (wr_cyc_q.size() > 0 ? wr_cyc_q[$] : -1), n + 21); end
        checks++; if (frame_count !== fc0 + 16'd1) begin errors++; $display("FAIL bp_count: got %0d, expected %0d", frame_count, fc0 + 16'd1); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_pending: %0d bytes never written, expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] g[3] = '{16'h1234, 16'hBEEF, 16'h0F0F};
        logic [63:0] a[3] = '{64'h0123_4567_89AB_CDEF, 64'hDEAD_0000_BEEF_1111, 64'h8000_0000_0000_0001};
        logic [31:0] d[3] = '{32'hCAFE_F00D, 32'h0000_0001, 32'h7F80_7F80};
        int acc[3];
        logic [15:0] fc0;
        clear_mon();
        fc0 = frame_count;
        for (int i = 0; i < 3; i++) begin
            wait_ready();
            req_gpreg = g[i];
            req_addr  = a[i];
            req_data  = d[i];
            req_valid = 1'b1;
            push_frame(g[i], a[i], d[i]);
            acc[i] = cyc;
            step();
        end
        req_valid = 1'b0;
        wait_cyc(acc[2] + 17);
        checks++; if (accepts != 3) begin errors++; $display("FAIL b2b_accepts: got %0d, expected 3", accepts); end
        checks++; if (acc[1] - acc[0] != 17 || acc[2] - acc[1] != 17) begin errors++; $display("FAIL b2b_period: got %0d/%0d, expected 17/17", acc[1] - acc[0], acc[2] - acc[1]); end
        checks++; if (wr_cyc_q.size() != 48) begin errors++; $display("FAIL b2b_len: got %0d bytes, expected 48", wr_cyc_q.size()); end
        checks++; if ((wr_cyc_q.size() == 48 ? wr_cyc_q[16] - wr_cyc_q[15] : -1) != 2) begin errors++; $display("FAIL b2b_gap: got %0d, expected 2", (wr_cyc_q.size() == 48 ? wr_cyc_q[16] - wr_cyc_q[15] : -1)); end
        checks++; if (frame_count !== fc0 + 16'd3) begin errors++; $display("FAIL b2b_count: got %0d, expected %0d", frame_count, fc0 + 16'd3); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: %0d bytes never written, expected 0", exp_q.size()); end
    endtask

    task automatic test_checksum_wrap();
        int n;
        clear_mon();
        send(16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, n);
        wait_cyc(n + 17);
        checks++; if ((wr_byte_q.size() == 16 ? wr_byte_q[15] : 8'hxx) !== 8'hF2) begin errors++; $display("FAIL wrap_csum: got %02h, expected F2", (wr_byte_q.size() == 16 ? wr_byte_q[15] : 8'hxx)); end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_mon();
        send(16'hA1A2, 64'h1122_3344_5566_7788, 32'h99AA_BBCC, n);
        wait_cyc(n + 9);
        #2;
        nrst = 1'b0;
        #1;
        checks++; if (fifo_wrreq !== 1'b0) begin errors++; $display("FAIL rst_wrreq: got %b, expected 0", fifo_wrreq); end
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_state: ready=%b busy=%b, expected 1/0", req_ready, busy); end
        checks++; if (fifo_data !== 8'h00 || frame_count !== 16'd0) begin errors++; $display("FAIL rst_outputs: data=%02h count=%0d, expected 00/0", fifo_data, frame_count); end
        checks++; if (wr_cyc_q.size() != 8) begin errors++; $display("FAIL rst_partial: got %0d bytes, expected 8", wr_cyc_q.size()); end
        exp_q.delete();
        step(); step();
        nrst = 1'b1;
        repeat (5) step();
        checks++; if (wr_cyc_q.size() != 8) begin errors++; $display("FAIL rst_leftover: got %0d bytes, expected 8", wr_cyc_q.size()); end
        clear_mon();
        send(16'h0002, 64'h20, 32'h30, n);
        wait_cyc(n + 17);
        checks++; if (wr_cyc_q.size() != 16 || (wr_byte_q.size() > 0 ? wr_byte_q[0] : 8'hxx) !== 8'hA5) begin errors++; $display("FAIL rst_newframe: got %0d bytes, first %02h, expected 16 bytes starting A5", wr_cyc_q.size(), (wr_byte_q.size() > 0 ? wr_byte_q[0] : 8'hxx)); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL rst_count: got %0d, expected 1", frame_count); end
    endtask

    task automatic test_counter_wrap();
        logic [1:0] seq[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        int m;
        int w;
        for (int i = 0; i < 5; i++) begin
            w = 0;
            while (req_ready2 !== 1'b1 && w <= 100) begin
                step();
                w++;
            end
            req_valid2 = 1'b1;
            m = cyc;
            step();
            req_valid2 = 1'b0;
            wait_cyc(m + 17);
            checks++;
            if (frame_count2 !== seq[i]) begin
                errors++;
                $display("FAIL cnt_wrap[%0d]: got %0d, expected %0d", i, frame_count2, seq[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_checksum_wrap();
        test_reset_mid();
        test_counter_wrap();
        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
